sbuf_drain_ctrl: RTL and testbench

- Sequences one systolic output pass: programs and pulses the output buffer's start, waits for its finish, then drains result words and saturation words into CPU data memory.
- Owns the output buffer's shared 9-bit read port and arbitrates it between the drain engine and direct CPU reads.
- Sits between the CPU register/config block, the output buffer (start/run_cntr/finish/sbus_radr/sbus_rdata) and the data-memory write port.

---
 rtl/sbuf_drain_ctrl.sv | 157 +++++++++++++++
 tb/tb_sbuf_drain_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbuf_drain_ctrl.sv
// rtl/sbuf_drain_ctrl.sv - output-buffer pass sequencer, read-port arbiter and data-memory drain engine
module sbuf_drain_ctrl #(
    parameter int DM_AW = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_go,
    input  logic [7:0]       cfg_len,
    input  logic [DM_AW-1:0] cfg_dst,
    input  logic             cfg_sat_en,
    input  logic             cfg_abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             start,
    output logic [7:0]       run_cntr,
    input  logic             s_running,
    input  logic             finish,
    output logic [8:0]       sbus_radr,
    input  logic [15:0]      sbus_rdata,
    input  logic             cpu_rreq,
    input  logic [8:0]       cpu_radr,
    output logic             cpu_rgnt,
    output logic [DM_AW-1:0] dm_wadr,
    output logic [15:0]      dm_wdata,
    output logic             dm_wen,
    input  logic             dm_wready
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_KICK     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_DRAIN_S  = 3'd3;
    localparam logic [2:0] S_DRAIN_SA = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    logic [2:0]       state;
    logic [7:0]       len_q;
    logic [DM_AW-1:0] dst_q;
    logic             sat_q;
    logic             fin_early;
    logic [7:0]       idx;
    logic             pend;
    logic             wen_q;
    logic [DM_AW-1:0] wadr_q;
    logic [15:0]      wdata_q;
    logic             err_q;

    logic             draining;
    logic             in_sat;
    logic [7:0]       last_idx;
    logic [DM_AW-1:0] wofs;
    logic [DM_AW-1:0] wadr_next;
    logic             unused_sig;

    assign unused_sig = s_running;

    assign draining  = (state == S_DRAIN_S) || (state == S_DRAIN_SA);
    assign in_sat    = (state == S_DRAIN_SA);
    // Saturation bank holds one word per 16 result words, rounded up by one.
    assign last_idx  = in_sat ? {4'd0, len_q[7:4]} : (len_q - 8'd1);
    assign wofs      = in_sat ? (DM_AW'(len_q) + DM_AW'(idx)) : DM_AW'(idx);
    assign wadr_next = dst_q + wofs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= 8'd0;
            dst_q     <= '0;
            sat_q     <= 1'b0;
            fin_early <= 1'b0;
            idx       <= 8'd0;
            pend      <= 1'b0;
            wen_q     <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_go) begin
                        if (cfg_len != 8'd0) begin
                            len_q     <= cfg_len;
                            dst_q     <= cfg_dst;
                            sat_q     <= cfg_sat_en;
                            fin_early <= 1'b0;
                            state     <= S_KICK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_KICK: begin
                    // A finish that lands while start is still out must not be lost.
                    fin_early <= finish;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    if (finish || fin_early) begin
                        fin_early <= 1'b0;
                        idx       <= 8'd0;
                        pend      <= 1'b0;
                        wen_q     <= 1'b0;
                        state     <= S_DRAIN_S;
                    end
                end
                S_DRAIN_S, S_DRAIN_SA: begin
                    if (wen_q) begin
                        if (dm_wready) begin
                            wen_q <= 1'b0;
                            if (idx == last_idx) begin
                                idx   <= 8'd0;
                                state <= (!in_sat && sat_q) ? S_DRAIN_SA : S_FIN;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end else if (pend) begin
                        pend    <= 1'b0;
                        wen_q   <= 1'b1;
                        wdata_q <= sbus_rdata;
                        wadr_q  <= wadr_next;
                    end else begin
                        pend <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (cfg_abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                wen_q     <= 1'b0;
                pend      <= 1'b0;
                idx       <= 8'd0;
                fin_early <= 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign err       = err_q;
    assign done      = (state == S_FIN) || err_q;
    assign start     = (state == S_KICK);
    assign run_cntr  = start ? len_q : 8'd0;
    assign cpu_rgnt  = cpu_rreq && !draining;
    assign sbus_radr = draining ? {in_sat, idx} : (cpu_rreq ? cpu_radr : 9'd0);
    assign dm_wen    = wen_q;
    assign dm_wadr   = wadr_q;
    assign dm_wdata  = wdata_q;

endmodule

// File: tb/tb_sbuf_drain_ctrl.sv
// tb/tb_sbuf_drain_ctrl.sv - self-checking bench for sbuf_drain_ctrl against a word-list model
module tb_sbuf_drain_ctrl;

    localparam int DM_AW = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_go;
    logic [7:0]       cfg_len;
    logic [DM_AW-1:0] cfg_dst;
    logic             cfg_sat_en;
    logic             cfg_abort;
    logic             busy;
    logic             done;
    logic             err;
    logic             start;
    logic [7:0]       run_cntr;
    logic             s_running;
    logic             finish;
    logic [8:0]       sbus_radr;
    logic [15:0]      sbus_rdata;
    logic             cpu_rreq;
    logic [8:0]       cpu_radr;
    logic             cpu_rgnt;
    logic [DM_AW-1:0] dm_wadr;
    logic [15:0]      dm_wdata;
    logic             dm_wen;
    logic             dm_wready;

    logic [15:0] res_mem [256];
    logic [15:0] sat_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sbuf_drain_ctrl #(.DM_AW(DM_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_go     (cfg_go),
        .cfg_len    (cfg_len),
        .cfg_dst    (cfg_dst),
        .cfg_sat_en (cfg_sat_en),
        .cfg_abort  (cfg_abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .start      (start),
        .run_cntr   (run_cntr),
        .s_running  (s_running),
        .finish     (finish),
        .sbus_radr  (sbus_radr),
        .sbus_rdata (sbus_rdata),
        .cpu_rreq   (cpu_rreq),
        .cpu_radr   (cpu_radr),
        .cpu_rgnt   (cpu_rgnt),
        .dm_wadr    (dm_wadr),
        .dm_wdata   (dm_wdata),
        .dm_wen     (dm_wen),
        .dm_wready  (dm_wready)
    );

    // Output buffer: registered read, data valid the cycle after the address
    always @(posedge clk)
        sbus_rdata <= sbus_radr[8] ? sat_mem[sbus_radr[7:0]] : res_mem[sbus_radr[7:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pass(input logic [7:0] len, input logic [11:0] dst, input logic sat,
                           input int fin_dly, input int stall_pct, input bit stall5,
                           input bit abort_drain, input bit go_abort);
        logic [27:0] exp_q[$];
        logic [27:0] held_v;
        logic [8:0]  exp_radr;
        bit          held;
        bit          last_acc;
        bit          got_done;
        bit          stalled;
        bit          rdy;
        int          cyc;
        int          writes;
        int          stall_left;
        int          nsa;

        for (int i = 0; i < 256; i++) begin
            res_mem[i] = 16'($urandom);
            sat_mem[i] = 16'($urandom);
        end
        for (int i = 0; i < int'(len); i++)
            exp_q.push_back({12'(dst + 12'(i)), res_mem[i]});
        nsa = int'(len) / 16 + 1;
        if (sat)
            for (int k = 0; k < nsa; k++)
                exp_q.push_back({12'(dst + 12'(len) + 12'(k)), sat_mem[k]});

        cfg_len = len; cfg_dst = dst; cfg_sat_en = sat;
        cfg_go = 1'b1; cfg_abort = go_abort;
        step();
        cfg_go = 1'b0; cfg_abort = 1'b0;
        chk("kick_start", 32'(start), 32'd1);
        chk("kick_run_cntr", 32'(run_cntr), 32'(len));
        chk("kick_busy", 32'(busy), 32'd1);
        if (fin_dly == 0) finish = 1'b1;
        step();
        finish = 1'b0;
        chk("run_start_low", 32'(start), 32'd0);
        chk("run_cntr_zero", 32'(run_cntr), 32'd0);
        cpu_rreq = 1'b1; cpu_radr = 9'($urandom);
        #1;
        chk("run_rgnt", 32'(cpu_rgnt), 32'd1);
        chk("run_radr", 32'(sbus_radr), 32'(cpu_radr));
        cpu_rreq = 1'b0;
        if (fin_dly > 0) begin
            for (int c = 1; c < fin_dly; c++) step();
            finish = 1'b1;
            step();
            finish = 1'b0;
        end else begin
            step();
        end

        held = 0; last_acc = 0; got_done = 0; stalled = 0;
        cyc = 0; writes = 0; stall_left = 0;
        while (!got_done && cyc < 5000) begin
            if (last_acc) chk("done_after_last", 32'(done), 32'd1);
            if (done) begin
                got_done = 1;
                chk("drained_all", 32'(exp_q.size()), 32'd0);
                break;
            end
            if (held) begin
                chk("hold_wen", 32'(dm_wen), 32'd1);
                chk("hold_val", 32'({dm_wadr, dm_wdata}), 32'(held_v));
            end
            cpu_rreq = 1'($urandom_range(0, 1)); cpu_radr = 9'($urandom);
            #1;
            chk("drain_rgnt", 32'(cpu_rgnt), 32'd0);
            if (dm_wen) begin
                chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("write", 32'({dm_wadr, dm_wdata}), 32'(exp_q[0]));
                exp_radr = (writes < int'(len)) ? {1'b0, 8'(writes)} : {1'b1, 8'(writes - int'(len))};
                chk("drain_radr", 32'(sbus_radr), 32'(exp_radr));
                if (abort_drain) begin
                    cfg_abort = 1'b1;
                    step();
                    cfg_abort = 1'b0; cpu_rreq = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_wen", 32'(dm_wen), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    for (int c = 0; c < 3; c++) begin
                        step();
                        chk("abort_no_done", 32'(done), 32'd0);
                    end
                    return;
                end
                if (stall5 && writes == 2 && !stalled) begin
                    stall_left = 5;
                    stalled = 1;
                end
            end
            rdy = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
            if (stall_left > 0) stall_left--;
            dm_wready = rdy;
            held = dm_wen && !rdy;
            held_v = {dm_wadr, dm_wdata};
            last_acc = dm_wen && rdy && (exp_q.size() == 1);
            if (dm_wen && rdy && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                writes++;
            end
            step();
            cyc++;
        end
        if (!got_done) chk("done_timeout", 32'(got_done), 32'd1);
        dm_wready = 1'b0; cpu_rreq = 1'b0;
        step();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; cfg_go = 1'b0; cfg_len = 8'd0; cfg_dst = '0; cfg_sat_en = 1'b0;
        cfg_abort = 1'b0; s_running = 1'b0; finish = 1'b0; cpu_rreq = 1'b0;
        cpu_radr = 9'd0; dm_wready = 1'b0;
        step(); step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_run_cntr", 32'(run_cntr), 32'd0);
        chk("rst_radr", 32'(sbus_radr), 32'd0);
        chk("rst_wen", 32'(dm_wen), 32'd0);
        chk("rst_wadr", 32'(dm_wadr), 32'd0);
        chk("rst_wdata", 32'(dm_wdata), 32'd0);
        chk("rst_rgnt0", 32'(cpu_rgnt), 32'd0);
        cpu_rreq = 1'b1;
        #1;
        chk("rst_rgnt1", 32'(cpu_rgnt), 32'd1);
        cpu_rreq = 1'b0;
        rst_n = 1'b1;
        step();

        do_pass(8'd4, 12'h100, 1'b0, 6, 0, 0, 0, 0);
        do_pass(8'd20, 12'h200, 1'b1, 3, 0, 0, 0, 0);
        do_pass(8'd12, 12'h040, 1'b0, 2, 0, 1, 0, 0);

        cfg_len = 8'd0; cfg_go = 1'b1;
        step();
        cfg_go = 1'b0;
        chk("zero_err", 32'(err), 32'd1);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_start", 32'(start), 32'd0);
        step();
        chk("zero_err_clr", 32'(err), 32'd0);
        chk("zero_done_clr", 32'(done), 32'd0);
        chk("zero_busy_after", 32'(busy), 32'd0);

        do_pass(8'd4, 12'hFFE, 1'b0, 0, 30, 0, 0, 0);
        do_pass(8'd6, 12'h300, 1'b0, 2, 0, 0, 1, 0);
        do_pass(8'd5, 12'h310, 1'b1, 1, 20, 0, 0, 0);
        do_pass(8'd3, 12'h020, 1'b0, 4, 0, 0, 0, 1);

        for (int p = 0; p < 6; p++)
            do_pass(8'($urandom_range(1, 60)), 12'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 8), $urandom_range(0, 60), 0, 0, 0);
        do_pass(8'd255, 12'hF80, 1'b1, 2, 25, 0, 0, 0);

        cfg_len = 8'd8; cfg_dst = 12'h050; cfg_sat_en = 1'b0; cfg_go = 1'b1;
        step();
        cfg_go = 1'b0; finish = 1'b1;
        step();
        finish = 1'b0;
        guard = 0;
        while (!dm_wen && guard < 50) begin
            step();
            guard++;
        end
        chk("midrst_reach_wen", 32'(dm_wen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wen", 32'(dm_wen), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
